serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 175 +++++++++++++++++
 tb/tb_serial_subtractor.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor
// -----------------------------------------------------------------------------
// Bit-serial two's-complement subtractor: Diff = A - B (mod 2^WIDTH), LSB first.
// One full-adder cell adds A to the inverted B with the carry seeded to 1, so
// the carry out of the MSB is the inverted borrow. A controller issues one
// operation at a time through a start/busy/done handshake.
//
// Parameters:
//   WIDTH  operand/result width in bits (>= 2), default 8
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous reset, active-high, highest priority
//   start  operation request, only looked at while idle
//   A      minuend, captured on the accepted start edge
//   B      subtrahend, captured on the accepted start edge
//   Diff   registered result A - B, holds until the next completion or reset
//   Bout   registered borrow, 1 iff A < B (unsigned)
//   busy   high during the WIDTH bit-processing cycles
//   done   one-cycle pulse in the cycle Diff/Bout first show a new result
//   V      (only with SERIAL_SUBTRACTOR_OVF_EN) signed-overflow flag
//
// Optional feature: define SERIAL_SUBTRACTOR_OVF_EN to add the V output.
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             busy,
  output logic             done
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             V
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] a_sh_q,   a_sh_d;
  logic [WIDTH-1:0] b_sh_q,   b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic             carry_q,  carry_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] diff_q,   diff_d;
  logic             bout_q,   bout_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic             v_q,      v_d;
`endif

  logic sum_bit;
  logic carry_out;
  logic b_inv;

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    v_d      = v_q;
`endif

    // The single full-adder cell: A + ~B + carry, one bit per cycle.
    b_inv     = ~b_sh_q[0];
    sum_bit   = a_sh_q[0] ^ b_inv ^ carry_q;
    carry_out = (a_sh_q[0] & b_inv) | (a_sh_q[0] & carry_q) | (b_inv & carry_q);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d   = A;
          b_sh_d   = B;
          res_sh_d = '0;
          carry_d  = 1'b1;
          cnt_d    = '0;
          state_d  = SHIFT;
          busy_d   = 1'b1;
        end
      end

      SHIFT: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_sh_d = {sum_bit, res_sh_q[WIDTH-1:1]};
        carry_d  = carry_out;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          // The result is committed on the edge into DONE so that Diff/Bout
          // are already valid in the cycle done is high, never partial.
          state_d = DONE;
          done_d  = 1'b1;
          diff_d  = {sum_bit, res_sh_q[WIDTH-1:1]};
          bout_d  = ~carry_out;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          // While processing the MSB, carry_q is the carry into the MSB.
          v_d     = carry_q ^ carry_out;
`endif
        end else begin
          busy_d = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      v_q      <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      v_q      <= v_d;
`endif
    end
  end

  assign Diff = diff_q;
  assign Bout = bout_q;
  assign busy = busy_q;
  assign done = done_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  assign V    = v_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
// -----------------------------------------------------------------------------
// Self-checking bench for serial_subtractor (WIDTH = 8). Expected results are
// queued when an operation is issued and compared when done pulses. Also
// watches reset values, result holding, busy length, latency, back-to-back
// throughput and the busy/done exclusion.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Diff;
  logic             Bout;
  logic             busy;
  logic             done;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic             V;
`endif

  typedef struct packed {
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             v;
  } exp_t;

  exp_t exp_q[$];
  int   done_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busy_run = 0;
  exp_t mon_e;
  exp_t last_e = '0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Diff  (Diff),
    .Bout  (Bout),
    .busy  (busy),
    .done  (done)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    .V     (V)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    e.diff = a - b;
    e.bout = (a < b);
    e.v    = (a[WIDTH-1] != b[WIDTH-1]) && (e.diff[WIDTH-1] != a[WIDTH-1]);
    return e;
  endfunction

  // Drive one request for a single cycle; leaves the bench at the negedge
  // just after the accepting edge, then scrambles A/B to prove capture.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    A     = a;
    B     = b;
    start = 1'b1;
    exp_q.push_back(model(a, b));
    @(negedge clk);
    start = 1'b0;
    A     = WIDTH'($urandom);
    B     = WIDTH'($urandom);
  endtask

  // Counts negedges since the accepting edge until done; must be WIDTH+1.
  task automatic waitDone();
    int n = 1;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("latency", n, WIDTH + 1);
  endtask

  // Output monitor: samples 1 ns after each rising edge.
  always begin
    @(posedge clk);
    #1;
    if (rst) begin
      checkOutput("rst_diff", Diff, 0);
      checkOutput("rst_bout", Bout, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      checkOutput("rst_v", V, 0);
`endif
      last_e   = '0;
      busy_run = 0;
    end else begin
      checkOutput("busy_done_overlap", busy && done, 0);
      if (busy) busy_run++;
      if (done) begin
        done_cyc.push_back(cyc);
        checkOutput("busy_len", busy_run, WIDTH);
        busy_run = 0;
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("diff", Diff, mon_e.diff);
          checkOutput("bout", Bout, mon_e.bout);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          checkOutput("v", V, mon_e.v);
`endif
          last_e = mon_e;
        end
      end else begin
        checkOutput("diff_hold", Diff, last_e.diff);
        checkOutput("bout_hold", Bout, last_e.bout);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        checkOutput("v_hold", V, last_e.v);
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [WIDTH-1:0] ta[8];
    logic [WIDTH-1:0] tb[8];
    logic [WIDTH-1:0] ha[3];
    logic [WIDTH-1:0] hb[3];
    int               base;

    ta = '{8'd5, 8'd3, 8'h00, 8'h00, 8'h80, 8'h7F, 8'hA5, 8'h3C};
    tb = '{8'd3, 8'd5, 8'h00, 8'h01, 8'h01, 8'hFF, 8'h00, 8'h3C};
    ha = '{8'd100, 8'd17, 8'h81};
    hb = '{8'd42, 8'd90, 8'h02};

    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed vectors: basic, borrow, boundaries, signed overflow, B=0, A=B.
    foreach (ta[i]) begin
      applyStimulus(ta[i], tb[i]);
      waitDone();
    end

    // Random operands.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(WIDTH'($urandom), WIDTH'($urandom));
      waitDone();
    end

    // start held high, operands scrambled mid-operation: each op uses only
    // what was present on its accepting edge, and ops finish every WIDTH+2.
    base = done_cyc.size();
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      A = ha[i];
      B = hb[i];
      exp_q.push_back(model(ha[i], hb[i]));
      repeat (3) @(negedge clk);
      A = WIDTH'($urandom);
      B = WIDTH'($urandom);
      repeat (7) @(negedge clk);
    end
    start = 1'b0;
    repeat (12) @(negedge clk);
    checkOutput("handshake_ops", done_cyc.size() - base, 3);
    if (done_cyc.size() - base == 3) begin
      checkOutput("period_1", done_cyc[base + 1] - done_cyc[base], WIDTH + 2);
      checkOutput("period_2", done_cyc[base + 2] - done_cyc[base + 1], WIDTH + 2);
    end

    // Reset in SHIFT cycle 4 aborts the op: no done, outputs cleared.
    applyStimulus(8'd200, 8'd100);
    repeat (3) @(negedge clk);
    checkOutput("busy_before_abort", busy, 1);
    rst = 1'b1;
    void'(exp_q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_diff", Diff, 0);
    repeat (12) @(negedge clk);

    applyStimulus(8'd9, 8'd4);
    waitDone();

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
